// File: rtl/axi_slave_pkg.sv
// Shared constants for the AXI3 SRAM slave: FSM encoding, response and burst
// codes, and the rule deciding whether a burst is served or answered SLVERR.
package axi_slave_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RD_REQ  = 3'd1;
    localparam state_t ST_RD_DATA = 3'd2;
    localparam state_t ST_WR_DATA = 3'd3;
    localparam state_t ST_WR_RESP = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [2:0] MAX_SIZE = 3'd2;

    // WRAP/reserved bursts and transfers wider than the 32-bit bus are refused.
    function automatic logic burst_illegal(input logic [1:0] burst, input logic [2:0] size);
        return !((burst == BURST_FIXED) || (burst == BURST_INCR)) || (size > MAX_SIZE);
    endfunction

endpackage

// File: rtl/axi_slave_addr_gen.sv
// Next beat address for the burst in flight; shared by the read and write paths.
module axi_slave_addr_gen
    import axi_slave_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr
);

    // Anything that is not INCR holds the address; refused bursts never write.
    always_comb begin
        next_addr = addr;
        if (burst == BURST_INCR) begin
            next_addr = addr + (32'd1 << size);
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave fronting a single-port synchronous SRAM. One burst in flight,
// round-robin AR/AW arbitration, INCR/FIXED bursts mapped to word accesses.
module axi_sram_slave
    import axi_slave_pkg::*;
#(
    parameter int MEM_AW = 16
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic [3:0]        arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic [1:0]        arlock,
    input  logic [3:0]        arcache,
    input  logic [2:0]        arprot,
    input  logic              arvalid,
    output logic              arready,

    output logic [3:0]        rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,

    input  logic [3:0]        awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic [1:0]        awlock,
    input  logic [3:0]        awcache,
    input  logic [2:0]        awprot,
    input  logic              awvalid,
    output logic              awready,

    input  logic [3:0]        wid,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,

    output logic [3:0]        bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,

    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [MEM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    state_t      state;
    logic        ready_en;
    logic        prio_w;
    logic        err;
    logic        rd_first;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [7:0]  beat_cnt;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] rdata_q;
    logic [31:0] next_addr;
    logic        idle;
    logic        ar_hs;
    logic        aw_hs;
    logic        w_hs;
    logic        last_beat;
    logic        unused;

    assign unused = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

    axi_slave_addr_gen u_addr_gen (
        .addr      (addr),
        .size      (size),
        .burst     (burst),
        .next_addr (next_addr)
    );

    // Both requesters valid: prio_w picks the winner, the loser waits in IDLE.
    assign idle    = (state == ST_IDLE);
    assign arready = ready_en && idle && !(awvalid && prio_w);
    assign awready = ready_en && idle && !(arvalid && !prio_w);
    assign ar_hs   = arvalid && arready;
    assign aw_hs   = awvalid && awready;

    assign last_beat = (beat_cnt == len);

    // First R cycle forwards the SRAM output; later stall cycles use the copy.
    assign rvalid = (state == ST_RD_DATA);
    assign rid    = id;
    assign rdata  = rd_first ? ram_rdata : rdata_q;
    assign rresp  = (rvalid && err) ? RESP_SLVERR : RESP_OKAY;
    assign rlast  = rvalid && last_beat;

    assign wready = (state == ST_WR_DATA);
    assign w_hs   = wready && wvalid;

    assign bvalid = (state == ST_WR_RESP);
    assign bid    = id;
    assign bresp  = (bvalid && err) ? RESP_SLVERR : RESP_OKAY;

    assign ram_en    = (state == ST_RD_REQ) || w_hs;
    assign ram_we    = (w_hs && !err) ? wstrb : 4'd0;
    assign ram_addr  = addr[MEM_AW+1:2];
    assign ram_wdata = wdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_en <= 1'b0;
            rd_first <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            ready_en <= 1'b1;
            rd_first <= (state == ST_RD_REQ);
            if (rd_first) begin
                rdata_q <= ram_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            prio_w   <= 1'b0;
            err      <= 1'b0;
            id       <= 4'd0;
            addr     <= 32'd0;
            len      <= 8'd0;
            beat_cnt <= 8'd0;
            size     <= 3'd0;
            burst    <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ar_hs) begin
                        id       <= arid;
                        addr     <= araddr;
                        len      <= arlen;
                        size     <= arsize;
                        burst    <= arburst;
                        err      <= burst_illegal(arburst, arsize);
                        beat_cnt <= 8'd0;
                        prio_w   <= ~prio_w;
                        state    <= ST_RD_REQ;
                    end else if (aw_hs) begin
                        id       <= awid;
                        addr     <= awaddr;
                        len      <= awlen;
                        size     <= awsize;
                        burst    <= awburst;
                        err      <= burst_illegal(awburst, awsize);
                        beat_cnt <= 8'd0;
                        prio_w   <= ~prio_w;
                        state    <= ST_WR_DATA;
                    end
                end
                ST_RD_REQ: begin
                    state <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (rready) begin
                        if (last_beat) begin
                            state <= ST_IDLE;
                        end else begin
                            addr     <= next_addr;
                            beat_cnt <= beat_cnt + 8'd1;
                            state    <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_DATA: begin
                    // Burst length, not wlast, ends the burst; a misplaced wlast
                    // only poisons the response and blocks further writes.
                    if (wvalid) begin
                        addr     <= next_addr;
                        beat_cnt <= beat_cnt + 8'd1;
                        if (wlast != last_beat) begin
                            err <= 1'b1;
                        end
                        if (last_beat) begin
                            state <= ST_WR_RESP;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (bready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI3 slave (responder) fronting a single-port synchronous SRAM. It serves as the memory-side endpoint for the cache/uncached AXI master bridge in simulation and in the FPGA memory subsystem. It accepts one read or write burst at a time, arbitrates AR against AW, and translates INCR/FIXED bursts into word-addressed SRAM accesses.

## Interface
- MEM_AW, 16: SRAM word-address width; memory size is 4·2^MEM_AW bytes.
- clk  in  1  rising-edge clock.
- resetn  in  1  reset, asynchronous and active-low.
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  in  4/32/8/3/2/2/4/3  AXI3 read address; lock/cache/prot ignored.
- arvalid  in  1; arready  out  1.
- rid  out  4; rdata  out  32; rresp  out  2; rlast  out  1; rvalid  out  1; rready  in  1.
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot  in  4/32/8/3/2/2/4/3  AXI3 write address; lock/cache/prot ignored.
- awvalid  in  1; awready  out  1.
- wid  in  4 (ignored); wdata  in  32; wstrb  in  4; wlast  in  1; wvalid  in  1; wready  out  1.
- bid  out  4; bresp  out  2; bvalid  out  1; bready  in  1.
- ram_en  out  1; ram_we  out  4; ram_addr  out  MEM_AW; ram_wdata  out  32; ram_rdata  in  32 (valid the cycle after ram_en with ram_we=0).

## Operation
- FSM states: IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP.
- IDLE: arready/awready asserted (gated by ready_en flop, 0 in reset, 1 from first clk after resetn rises). Both valid: round-robin; priority flips after each granted burst; initial priority read. arready = ready_en && IDLE && !(awvalid && prio_w); awready symmetric.
- On AR handshake: latch id, addr, len, size, burst; beat_cnt=0; err = (arburst ∉ {FIXED,INCR}) || arsize>2 → RD_REQ.
- RD_REQ: ram_en=1, ram_we=0, ram_addr=addr[MEM_AW+1:2] → RD_DATA.
- RD_DATA: capture ram_rdata into rdata register on entry cycle; rvalid=1, rid=latched id, rresp=err?SLVERR(2'b10):OKAY, rlast=(beat_cnt==len). rdata/rresp/rlast stable while rready=0. On rready: last → IDLE; else addr=next, beat_cnt++ → RD_REQ.
- On AW handshake: latch id, addr, len, size, burst, err as above; beat_cnt=0 → WR_DATA.
- WR_DATA: wready=1. Each w handshake: ram_en=1, ram_we=err?0:wstrb, ram_wdata=wdata, ram_addr current; addr=next, beat_cnt++. wlast≠(beat_cnt==len) sets err (sticky). At beat_cnt==len handshake → WR_RESP (wlast ignored for termination).
- WR_RESP: bvalid=1, bid, bresp=err?SLVERR:OKAY; held until bready → IDLE.
- Address gen: FIXED next=addr; INCR next=addr+(1<<size), 32-bit wrap. Bits above MEM_AW+1 ignored (aliasing). Reads return the full word; lane selection is the master's job.
- rresp/bresp never EXOKAY/DECERR.

## Timing
- Reset (async assert): state IDLE, all valid/ready outputs 0, ram_en=0, ram_we=0, rid/bid/rresp/bresp/rlast/rdata=0, prio read.
- Read: AR handshake at cycle N → ram_en at N+1 → rvalid at N+2; with rready=1, one beat per 2 cycles.
- Write: AW handshake N → wready from N+1; one beat per cycle; bvalid the cycle after final beat.
- Reset mid-burst: burst dropped, no response; outputs return to reset values immediately.
- No new AR/AW accepted until the current burst's final R beat or B handshake completes.

## Structure
- Package axi_slave_pkg: state enum, RESP_OKAY/RESP_SLVERR, BURST_FIXED/INCR/WRAP constants, MAX_SIZE=2.
- Sub-module axi_slave_addr_gen: combinational next-address from addr/size/burst, shared by both paths.

## Test plan
- Write len=0, addr 0x100, wdata 0xDEADBEEF, wstrb 4'hF; then read 0x100 → bresp OKAY, rdata 0xDEADBEEF, rlast=1, rid=awid.
- INCR write len=3 size=2 at 0x200, data 1..4; read back len=3 with rready toggling every cycle → rdata 1,2,3,4, rlast only on 4th, data stable while stalled.
- wstrb 4'b0011 write 0xAAAA5555 over 0xFFFFFFFF → read 0xFFFF5555.
- arvalid and awvalid together twice → first read granted, then write; alternating thereafter.
- arburst=WRAP len=1 → 2 beats both rresp SLVERR; awsize=3 write → ram_we=0 throughout, bresp SLVERR.
- wlast asserted on beat 1 of len=2 → 3 beats still accepted, bresp SLVERR; resetn low mid-read → rvalid 0 same cycle, next AR accepted normally.
